modn_updown_counter: RTL and testbench
======================================

// Module: modn_updown_counter
// PURPOSE
//  Parametrised modulo-N up/down counter; successor to the fixed mod-10 counter.
//  Adds direction control, count enable, parallel load with range checking, and a
//  selectable wrap or saturate mode. Its carry/borrow output cascades digit counters
//  (e.g. BCD timers); a wrap-event tally supports debug.
// PARAMETERS
//  MODULUS   10  number of states, count range 0..MODULUS-1; must be >= 2
//  WIDTH     $clog2(MODULUS)  count width (localparam, derived; not overridable)
//  SATURATE  0   0 = wrap at terminal value, 1 = hold at terminal value
//  TALLY_W   8   width of the wrap-event tally counter
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        synchronous, active-high reset
//  en         in   1        count enable (cascade: connect to previous stage tc)
//  up         in   1        direction: 1 = up, 0 = down
//  load       in   1        parallel load strobe
//  load_val   in   WIDTH    value to load
//  count      out  WIDTH    current count (registered)
//  tc         out  1        terminal count / carry-borrow (combinational)
//  at_max     out  1        count == MODULUS-1 (combinational from count)
//  at_min     out  1        count == 0 (combinational from count)
//  load_err   out  1        registered 1-cycle pulse: out-of-range load was clamped
//  wrap_cnt   out  TALLY_W  number of wrap/saturate-hit events, saturating
// BEHAVIOUR
//  Clocking and reset
//  - One clock. Reset is synchronous and active-high.
//  - Reset sets count=0, load_err=0 and wrap_cnt=0. This holds regardless of en or load.
//  - Reset mid-count takes effect at the next edge; there is no partial update.
//  Update priority per edge: reset > load > en. If en=0 and load=0, count holds.
//  Load
//  - If load_val < MODULUS: count <= load_val and load_err <= 0.
//  - If load_val >= MODULUS: count <= MODULUS-1 and load_err <= 1.
//  - Load overrides en; a load never increments wrap_cnt.
//  - load_err is 0 on every cycle that is not an out-of-range load.
//  Counting (en=1, load=0)
//  - Up, count < MODULUS-1: count+1.
//  - Up, count == MODULUS-1: wrap mode -> 0; saturate mode -> hold.
//  - Down, count > 0: count-1.
//  - Down, count == 0: wrap mode -> MODULUS-1; saturate mode -> hold.
//  - Direction may change on any cycle. The new up value applies on that same edge.
//  Terminal count
//  - tc = en & ~load & (up ? at_max : at_min). It is high in the cycle before the wrap edge.
//  - tc behaves the same in saturate mode. It does not re-check reset.
//  - Cascade: the next stage's en = tc. A chain advances exactly once per wrap.
//  Wrap tally
//  - wrap_cnt increments on every edge where tc=1 and reset=0.
//  - It sticks at 2^TALLY_W-1 and never rolls over.
//  Arithmetic and elaboration checks
//  - All arithmetic is unsigned. count never holds a value >= MODULUS.
//  - A non-power-of-2 MODULUS leaves the upper codes unreachable.
//  - MODULUS < 2 is an elaboration error (generate-time $error).
//  - MODULUS=2^k is legal; WIDTH=k.
// TESTING (MODULUS=10 unless noted)
//  1 Reset 2 cyc, en=1 up=1 for 25 cyc: count 0..9,0..9,0..4.
//    Expect tc at count=9 (2x), wrap_cnt=2.
//  2 Down from 0, en=1 up=0: 0,9,8,...; tc high at count=0.
//    Flip up mid-run at count=5 -> next count=6.
//  3 load_val=7 -> count=7, load_err=0. load_val=12 -> count=9, load_err=1 for one cycle.
//    load+en same cycle -> load wins.
//  4 SATURATE=1: up from 8 -> 9,9,9 with wrap_cnt +1 per held cycle.
//    Down from 1 -> 0,0.
//  5 Reset asserted with count=6, en=1, load=1 -> count=0, wrap_cnt=0, load_err=0 next edge.
//  6 Two stages cascaded (ones.tc -> tens.en), 100 en cycles.
//    Expect tens=0 and ones=0 after wrap; tens.tc asserted once at 99.
//    Add TALLY_W=2 saturation check at 3.

Source files
------------

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with load clamp, wrap/saturate mode and a sticky wrap-event tally.
// Latency: count, load_err and wrap_cnt update one edge after their inputs; tc, at_max and at_min are combinational.
// Backpressure: none; en=0 stalls the count, and a cascade feeds tc into the next stage's en.
module modn_updown_counter #(
    parameter int MODULUS  = 10,
    parameter bit SATURATE = 1'b0,
    parameter int TALLY_W  = 8,
    localparam int WIDTH   = (MODULUS < 2) ? 1 : $clog2(MODULUS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               up,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               at_max,
    output logic               at_min,
    output logic               load_err,
    output logic [TALLY_W-1:0] wrap_cnt
);

    localparam logic [WIDTH-1:0]   MAX_VAL   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]     MOD_VAL   = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0]   CNT_ONE   = WIDTH'(1);
    localparam logic [TALLY_W-1:0] TALLY_MAX = '1;
    localparam logic [TALLY_W-1:0] TALLY_ONE = TALLY_W'(1);

    generate
        if (MODULUS < 2) begin : g_bad_modulus
            $error("modn_updown_counter: MODULUS must be >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] count_nxt;
    logic             load_oor;

    assign at_max   = (count == MAX_VAL);
    assign at_min   = (count == '0);
    assign tc       = en & ~load & (up ? at_max : at_min);
    // One extra bit so a power-of-2 modulus compares without truncation.
    assign load_oor = ({1'b0, load_val} >= MOD_VAL);

    always_comb begin
        count_nxt = count;
        if (load) begin
            count_nxt = load_oor ? MAX_VAL : load_val;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    count_nxt = count + CNT_ONE;
                end else if (!SATURATE) begin
                    count_nxt = '0;
                end
            end else begin
                if (!at_min) begin
                    count_nxt = count - CNT_ONE;
                end else if (!SATURATE) begin
                    count_nxt = MAX_VAL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            load_err <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            count    <= count_nxt;
            load_err <= load & load_oor;
            // A held terminal value in saturate mode keeps tc high, so each held cycle counts.
            if (tc && (wrap_cnt != TALLY_MAX)) begin
                wrap_cnt <= wrap_cnt + TALLY_ONE;
            end
        end
    end

endmodule

// File: tb/tb_modn_updown_counter.sv
// Bench for modn_updown_counter: wrap, saturate and power-of-2 instances share one stimulus stream,
// plus a two-digit cascade driven separately.
module tb_modn_updown_counter;

    logic       clk;
    logic       reset, en, up, load;
    logic [3:0] load_val;

    logic [3:0] count_w;  logic tc_w, amax_w, amin_w, err_w; logic [7:0] tal_w;
    logic [3:0] count_s;  logic tc_s, amax_s, amin_s, err_s; logic [1:0] tal_s;
    logic [2:0] count_p;  logic tc_p, amax_p, amin_p, err_p; logic [7:0] tal_p;

    logic       c_reset, c_en;
    logic [3:0] ones_count, tens_count;
    logic       ones_tc, tens_tc, ones_amax, ones_amin, tens_amax, tens_amin, ones_err, tens_err;
    logic [7:0] ones_tal, tens_tal;

    modn_updown_counter #(.MODULUS(10), .SATURATE(1'b0), .TALLY_W(8)) u_w (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count_w), .tc(tc_w), .at_max(amax_w), .at_min(amin_w), .load_err(err_w), .wrap_cnt(tal_w));

    modn_updown_counter #(.MODULUS(10), .SATURATE(1'b1), .TALLY_W(2)) u_s (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count_s), .tc(tc_s), .at_max(amax_s), .at_min(amin_s), .load_err(err_s), .wrap_cnt(tal_s));

    modn_updown_counter #(.MODULUS(8), .SATURATE(1'b0), .TALLY_W(8)) u_p (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[2:0]),
        .count(count_p), .tc(tc_p), .at_max(amax_p), .at_min(amin_p), .load_err(err_p), .wrap_cnt(tal_p));

    modn_updown_counter #(.MODULUS(10), .SATURATE(1'b0), .TALLY_W(8)) u_ones (
        .clk(clk), .reset(c_reset), .en(c_en), .up(1'b1), .load(1'b0), .load_val(4'd0),
        .count(ones_count), .tc(ones_tc), .at_max(ones_amax), .at_min(ones_amin), .load_err(ones_err), .wrap_cnt(ones_tal));

    modn_updown_counter #(.MODULUS(10), .SATURATE(1'b0), .TALLY_W(8)) u_tens (
        .clk(clk), .reset(c_reset), .en(ones_tc), .up(1'b1), .load(1'b0), .load_val(4'd0),
        .count(tens_count), .tc(tens_tc), .at_max(tens_amax), .at_min(tens_amin), .load_err(tens_err), .wrap_cnt(tens_tal));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int ncmp  = 0;
    int nfail = 0;

    // Reference state per instance: 0 = wrap mod 10, 1 = saturate mod 10 (2-bit tally), 2 = wrap mod 8.
    int mc[3], me[3], mt[3];
    bit mvalid = 1'b0;
    bit last_tc_w;

    function automatic int modof(int i);  return (i == 2) ? 8 : 10;  endfunction
    function automatic bit satof(int i);  return (i == 1);           endfunction
    function automatic int tmaxof(int i); return (i == 1) ? 3 : 255; endfunction

    function automatic int act_cnt(int i);
        if (i == 0) return int'(count_w);
        if (i == 1) return int'(count_s);
        return int'(count_p);
    endfunction
    function automatic int act_tc(int i);
        if (i == 0) return int'(tc_w);
        if (i == 1) return int'(tc_s);
        return int'(tc_p);
    endfunction
    function automatic int act_amax(int i);
        if (i == 0) return int'(amax_w);
        if (i == 1) return int'(amax_s);
        return int'(amax_p);
    endfunction
    function automatic int act_amin(int i);
        if (i == 0) return int'(amin_w);
        if (i == 1) return int'(amin_s);
        return int'(amin_p);
    endfunction
    function automatic int act_err(int i);
        if (i == 0) return int'(err_w);
        if (i == 1) return int'(err_s);
        return int'(err_p);
    endfunction
    function automatic int act_tal(int i);
        if (i == 0) return int'(tal_w);
        if (i == 1) return int'(tal_s);
        return int'(tal_p);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_tc(int i, bit e, bit u, bit l);
        return e && !l && (u ? (mc[i] == modof(i) - 1) : (mc[i] == 0));
    endfunction

    task automatic model_step(input int i, input bit r, e, u, l, input int v);
        int m, lv;
        bit t;
        m  = modof(i);
        lv = (i == 2) ? (v & 7) : v;
        t  = model_tc(i, e, u, l);
        if (r) begin
            mc[i] = 0; me[i] = 0; mt[i] = 0;
        end else begin
            if (t && mt[i] < tmaxof(i)) mt[i]++;
            me[i] = 0;
            if (l) begin
                if (lv < m) mc[i] = lv;
                else begin mc[i] = m - 1; me[i] = 1; end
            end else if (e) begin
                if (u) mc[i] = (mc[i] < m - 1) ? mc[i] + 1 : (satof(i) ? mc[i] : 0);
                else   mc[i] = (mc[i] > 0)     ? mc[i] - 1 : (satof(i) ? mc[i] : m - 1);
            end
        end
    endtask

    // Called just after a rising edge; applies inputs, checks combinational outputs, clocks, checks state.
    task automatic step(input bit r, e, u, l, input int v);
        reset = r; en = e; up = u; load = l; load_val = 4'(v);
        #1;
        last_tc_w = tc_w;
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("tc[%0d]", i),     act_tc(i),   int'(model_tc(i, e, u, l)));
                chk($sformatf("at_max[%0d]", i), act_amax(i), int'(mc[i] == modof(i) - 1));
                chk($sformatf("at_min[%0d]", i), act_amin(i), int'(mc[i] == 0));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) model_step(i, r, e, u, l, v);
        if (r) mvalid = 1'b1;
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("count[%0d]", i),    act_cnt(i), mc[i]);
                chk($sformatf("load_err[%0d]", i), act_err(i), me[i]);
                chk($sformatf("wrap_cnt[%0d]", i), act_tal(i), mt[i]);
            end
        end
    endtask

    typedef struct {
        bit r, e, u, l;
        int v;
        int cnt, tc, err, tal;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int ntc;
        reset = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 4'd0;
        c_reset = 1'b1; c_en = 1'b0;

        // Expected values for the mod-10 wrap instance; tc is the value just before the edge.
        tbl[0]  = '{0,0,1,0, 0,  0,0,0,0};
        tbl[1]  = '{0,1,0,0, 0,  9,1,0,1};
        tbl[2]  = '{0,1,0,0, 0,  8,0,0,1};
        tbl[3]  = '{0,1,1,1, 7,  7,0,0,1};
        tbl[4]  = '{0,1,1,0, 0,  8,0,0,1};
        tbl[5]  = '{0,0,1,1, 12, 9,0,1,1};
        tbl[6]  = '{0,0,1,0, 0,  9,0,0,1};
        tbl[7]  = '{0,1,1,0, 0,  0,1,0,2};
        tbl[8]  = '{0,1,1,1, 15, 9,0,1,2};
        tbl[9]  = '{0,1,0,1, 10, 9,0,1,2};
        tbl[10] = '{0,1,0,1, 9,  9,0,0,2};
        tbl[11] = '{1,1,1,1, 3,  0,0,0,0};
        tbl[12] = '{0,1,1,0, 0,  1,0,0,0};

        @(posedge clk); #1;
        step(1, 1, 1, 1, 5);
        chk("reset_count", int'(count_w), 0);
        chk("reset_err",   int'(err_w),   0);
        chk("reset_tally", int'(tal_w),   0);

        foreach (tbl[k]) begin
            step(tbl[k].r, tbl[k].e, tbl[k].u, tbl[k].l, tbl[k].v);
            chk($sformatf("tbl%0d_count", k), int'(count_w),   tbl[k].cnt);
            chk($sformatf("tbl%0d_tc", k),    int'(last_tc_w), tbl[k].tc);
            chk($sformatf("tbl%0d_err", k),   int'(err_w),     tbl[k].err);
            chk($sformatf("tbl%0d_tally", k), int'(tal_w),     tbl[k].tal);
        end

        // Two reset cycles, then 24 up edges: values 0..9,0..9,0..4.
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        ntc = 0;
        for (int k = 0; k < 24; k++) begin
            step(0, 1, 1, 0, 0);
            if (last_tc_w) ntc++;
        end
        chk("up_run_count", int'(count_w), 4);
        chk("up_run_tc",    ntc,           2);
        chk("up_run_tally", int'(tal_w),   2);

        // Down from 0 wraps to 9, run to 5, then flip to up.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("down_tc_at_0", int'(last_tc_w), 1);
        chk("down_wrap",    int'(count_w),   9);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0);
        chk("down_at_5", int'(count_w), 5);
        step(0, 1, 1, 0, 0);
        chk("flip_up", int'(count_w), 6);

        // Saturate: up from 8 holds at 9 and the 2-bit tally sticks at 3.
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 8);
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0);
        chk("sat_hold9",  int'(count_s), 9);
        chk("sat_tally2", int'(tal_s),   2);
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0);
        chk("sat_tally_stick", int'(tal_s), 3);
        step(0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("sat_hold0", int'(count_s), 0);

        // Reset beats load and en mid-count.
        step(0, 0, 1, 1, 9);
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 6);
        chk("pre_reset_count", int'(count_w), 6);
        step(1, 1, 1, 1, 14);
        chk("rst_count", int'(count_w), 0);
        chk("rst_tally", int'(tal_w),   0);
        chk("rst_err",   int'(err_w),   0);

        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 5) == 0, int'($urandom_range(0, 15)));
        end

        // Cascade: ones.tc drives tens.en over 100 enabled cycles.
        reset = 1'b0; en = 1'b0; load = 1'b0;
        c_reset = 1'b1;
        @(posedge clk); #1;
        c_reset = 1'b0; c_en = 1'b1;
        ntc = 0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (k % 10 == 0 || k >= 98) begin
                chk($sformatf("casc_ones@%0d", k), int'(ones_count), k % 10);
                chk($sformatf("casc_tens@%0d", k), int'(tens_count), (k / 10) % 10);
            end
            if (tens_tc) ntc++;
            if (k == 99) chk("casc_tens_tc@99", int'(tens_tc), 1);
            @(posedge clk); #1;
        end
        c_en = 1'b0;
        chk("casc_ones_end",  int'(ones_count), 0);
        chk("casc_tens_end",  int'(tens_count), 0);
        chk("casc_tens_tc_n", ntc,              1);
        chk("casc_ones_tal",  int'(ones_tal),   10);
        chk("casc_tens_tal",  int'(tens_tal),   1);
        chk("casc_err",       int'(ones_err | tens_err), 0);
        chk("casc_min_flags", int'(ones_amin & tens_amin & ~ones_amax & ~tens_amax), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
